// File: rtl/mdu_alu.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module mdu_alu #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] inp1,
   input  logic [n-1:0] inp2,
   input  logic [3:0]   aluop,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] alu_out,
   output logic         zero
);

   localparam int SHW = $clog2(n);
   localparam int CW  = SHW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [3:0]    op_r;
   logic [n-1:0]  addend, hi, lo, hi_nx, lo_nx, step_res, alu_res;
   logic [n:0]    sum, shv;
   logic          accept, multi, ge;

   function automatic logic is_multi(input logic [3:0] op);
      return op inside {4'b1001, 4'b1010, 4'b1011, 4'b1100};
   endfunction

   function automatic logic is_mul(input logic [3:0] op);
      return op inside {4'b1001, 4'b1010};
   endfunction

   function automatic logic [n-1:0] alu_fn(input logic [3:0] op, input logic [n-1:0] a,
                                           input logic [n-1:0] b);
      logic signed [n-1:0] sa, sb;
      logic [SHW-1:0]      sh;
      sa = a;
      sb = b;
      sh = b[SHW-1:0];
      case (op)
         4'b0000: alu_fn = a + b;
         4'b0001: alu_fn = a << sh;
         4'b0010: alu_fn = {{(n-1){1'b0}}, (sa < sb)};
         4'b0011: alu_fn = {{(n-1){1'b0}}, (a < b)};
         4'b0100: alu_fn = a ^ b;
         4'b0101: alu_fn = a >> sh;
         4'b0110: alu_fn = a | b;
         4'b0111: alu_fn = a & b;
         4'b1000: alu_fn = a - b;
         4'b1101: alu_fn = sa >>> sh;
         default: alu_fn = '0;
      endcase
   endfunction

   assign accept  = in_valid && (state == IDLE);
   assign multi   = is_multi(aluop);
   assign alu_res = alu_fn(aluop, inp1, inp2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = multi ? BUSY : DONE;
         BUSY:    if (cnt == CW'(1)) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Iteration step: {hi,lo} is the product register for multiply and the
   // {remainder,quotient} pair for divide; addend is multiplicand or divisor.
   always_comb begin
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
      shv   = {hi, lo[n-1]};
      ge    = (shv >= {1'b0, addend});
      hi_nx = hi;
      lo_nx = lo;
      if (is_mul(op_r)) begin
         hi_nx = sum[n:1];
         lo_nx = {sum[0], lo[n-1:1]};
      end else begin
         hi_nx = ge ? (shv[n-1:0] - addend) : shv[n-1:0];
         lo_nx = {lo[n-2:0], ge};
      end
      case (op_r)
         4'b1001: step_res = lo_nx;
         4'b1010: step_res = hi_nx;
         4'b1011: step_res = lo_nx;
         default: step_res = hi_nx;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_r <= aluop;
         hi   <= '0;
         if (is_mul(aluop)) begin
            addend <= inp1;
            lo     <= inp2;
         end else begin
            addend <= inp2;
            lo     <= inp1;
         end
      end else if (state == BUSY) begin
         hi <= hi_nx;
         lo <= lo_nx;
      end
   end

   // Result register: written on accept for single-cycle ops, on the last step otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         alu_out <= '0;
         zero    <= 1'b0;
      end else if (accept) begin
         if (multi) begin
            cnt <= CW'(n);
         end else begin
            alu_out <= alu_res;
            zero    <= (alu_res == '0);
         end
      end else if (state == BUSY) begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            alu_out <= step_res;
            zero    <= (step_res == '0);
         end
      end
   end

endmodule

// File: tb/tb_mdu_alu.sv
// Testbench for mdu_alu (n=32): directed vector table, randomized ops against
// an arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_mdu_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] inp1, inp2;
   logic [3:0]  aluop;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_out;
   logic        zero;

   int checks = 0;
   int passes = 0;

   mdu_alu #(.n(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .inp1(inp1), .inp2(inp2), .aluop(aluop), .out_valid(out_valid),
      .out_ready(out_ready), .alu_out(alu_out), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      int unsigned s;
      p = {32'b0, a} * {32'b0, b};
      s = b % 32;
      case (op)
         4'd0:    return a + b;
         4'd1:    return a << s;
         4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd3:    return (a < b) ? 32'd1 : 32'd0;
         4'd4:    return a ^ b;
         4'd5:    return a >> s;
         4'd6:    return a | b;
         4'd7:    return a & b;
         4'd8:    return a - b;
         4'd9:    return p[31:0];
         4'd10:   return p[63:32];
         4'd11:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd12:   return (b == 0) ? a : a % b;
         4'd13:   return $signed(a) >>> s;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] op);
      return (op >= 4'd9 && op <= 4'd12) ? 33 : 1;
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output logic z,
                         output int lat, output bit busy_ok, output bit stable,
                         output bit done_ok);
      int t;
      busy_ok = 1'b1;
      stable  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      in_valid = 1'b1; aluop = op; inp1 = a; inp2 = b; out_ready = 1'b0;
      @(posedge clk); #1;
      lat = 1;
      while (!out_valid && lat < 200) begin
         if (in_ready) busy_ok = 1'b0;
         in_valid = 1'($urandom % 2); aluop = 4'($urandom); inp1 = $urandom; inp2 = $urandom;
         @(posedge clk); #1;
         lat++;
      end
      res = alu_out;
      z   = zero;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; aluop = 4'($urandom); inp1 = $urandom; inp2 = $urandom;
         @(posedge clk); #1;
         if (!out_valid || alu_out !== res || zero !== z) stable = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      done_ok = !out_valid && in_ready;
      @(posedge clk); #1;
      if (out_valid) done_ok = 1'b0;
   endtask

   logic [31:0] r, ra, rb, e;
   logic [3:0]  rop;
   logic        zz;
   int          lat, t;
   bit          bo, st, dn, seen;

   initial begin
      tv[0]  = '{4'b0000, 32'd5,         32'd7,         32'd12,        1};
      tv[1]  = '{4'b1000, 32'd7,         32'd7,         32'd0,         1};
      tv[2]  = '{4'b0010, 32'hFFFF_FFFF, 32'd1,         32'd1,         1};
      tv[3]  = '{4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd0,         1};
      tv[4]  = '{4'b1101, 32'h8000_0000, 32'd4,         32'hF800_0000, 1};
      tv[5]  = '{4'b0001, 32'd1,         32'd33,        32'd2,         1};
      tv[6]  = '{4'b1001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 33};
      tv[7]  = '{4'b1010, 32'hFFFF_FFFF, 32'd2,         32'd1,         33};
      tv[8]  = '{4'b1011, 32'd100,       32'd7,         32'd14,        33};
      tv[9]  = '{4'b1100, 32'd100,       32'd7,         32'd2,         33};
      tv[10] = '{4'b1011, 32'd5,         32'd0,         32'hFFFF_FFFF, 33};
      tv[11] = '{4'b1100, 32'd5,         32'd0,         32'd5,         33};
      tv[12] = '{4'b0101, 32'h8000_0000, 32'd36,        32'h0800_0000, 1};
      tv[13] = '{4'b1110, 32'hDEAD,      32'h1234,      32'd0,         1};
      tv[14] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1};
      tv[15] = '{4'b0100, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      aluop = 4'd0; inp1 = '0; inp2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset alu_out", alu_out, 0);
      chk("reset zero", zero, 0);
      chk("reset out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready after reset", in_ready, 1);

      for (int i = 0; i < 16; i++) begin
         run_op(tv[i].op, tv[i].a, tv[i].b, 0, r, zz, lat, bo, st, dn);
         chk($sformatf("vec%0d result", i), r, tv[i].exp);
         chk($sformatf("vec%0d zero", i), zz, (tv[i].exp == 0));
         chk($sformatf("vec%0d latency", i), lat, tv[i].lat);
         chk($sformatf("vec%0d handshake", i), dn, 1);
         if (tv[i].lat > 1) chk($sformatf("vec%0d in_ready low while busy", i), bo, 1);
      end

      run_op(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 10, r, zz, lat, bo, st, dn);
      chk("bp result", r, 32'h0000_FF00);
      chk("bp held", st, 1);
      chk("bp returned once", dn, 1);
      run_op(4'b1001, 32'd1234, 32'd5678, 4, r, zz, lat, bo, st, dn);
      chk("bp mul result", r, 32'd7006652);
      chk("bp mul held", st, 1);
      chk("bp mul returned once", dn, 1);

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom);
         ra  = $urandom;
         rb  = ($urandom % 4 == 0) ? ($urandom % 8) : $urandom;
         e   = model(rop, ra, rb);
         run_op(rop, ra, rb, $urandom % 3, r, zz, lat, bo, st, dn);
         chk($sformatf("rand%0d op%0h a=%h b=%h result", i, rop, ra, rb), r, e);
         chk($sformatf("rand%0d zero", i), zz, (e == 0));
         chk($sformatf("rand%0d latency", i), lat, model_lat(rop));
         chk($sformatf("rand%0d handshake", i), dn && st && bo, 1);
      end

      @(negedge clk);
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      in_valid = 1'b1; aluop = 4'b1011; inp1 = 32'd100; inp2 = 32'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset alu_out", alu_out, 0);
      chk("midreset zero", zero, 0);
      chk("midreset out_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; aluop = 4'b0000; inp1 = 32'h1234; inp2 = 32'h1111;
      #1;
      chk("in_ready after midreset", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post-reset add valid", out_valid, 1);
      chk("post-reset add result", alu_out, 32'h2345);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("discarded op never presented", seen, 0);

      run_op(4'b0110, 32'h0F00_0000, 32'h0000_00F0, 0, r, zz, lat, bo, st, dn);
      chk("final or result", r, 32'h0F00_00F0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mdu_alu.md
MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 SHALL have parameter n, default 32, datapath width in bits; legal values are powers of two, 8 to 64.
REQ-002 SHALL have derived localparam SHW = $clog2(n), the shift-amount width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and opcode presented.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port inp1  input  n  operand A (dividend, multiplicand, shift source).
REQ-008 SHALL have port inp2  input  n  operand B (divisor, multiplier, shift amount).
REQ-009 SHALL have port aluop  input  4  operation select.
REQ-010 SHALL have port out_valid  output  1  result held on alu_out/zero.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port alu_out  output  n  registered result.
REQ-013 SHALL have port zero  output  1  registered flag, high when alu_out == 0.

Function
REQ-014 SHALL accept an operation on a rising edge where in_valid && in_ready, capturing inp1, inp2 and aluop.
REQ-015 SHALL implement aluop: 0000 ADD; 0001 SLL; 0010 SLT (signed); 0011 SLTU; 0100 XOR; 0101 SRL; 0110 OR; 0111 AND; 1000 SUB; 1101 SRA (arithmetic).
REQ-016 SHALL implement aluop: 1001 MUL (low n bits of unsigned product); 1010 MULHU (high n bits); 1011 DIVU; 1100 REMU.
REQ-017 SHALL produce alu_out = 0 for reserved codes 1110 and 1111.
REQ-018 SHALL use only inp2[SHW-1:0] as the shift amount for SLL, SRL and SRA.
REQ-019 SHALL wrap ADD and SUB modulo 2^n, with no carry or overflow output.
REQ-020 SHALL write SLT and SLTU results as 1 or 0, zero-extended to n bits.
REQ-021 SHALL use a state machine with states IDLE, BUSY and DONE.
REQ-022 SHALL drive in_ready = 1 only in IDLE.
REQ-023 SHALL drive out_valid = 1 only in DONE.
REQ-024 SHALL move IDLE->DONE on acceptance of a single-cycle op (codes 0000-1000, 1101, 1110, 1111), with out_valid high on the next cycle (latency 1).
REQ-025 SHALL move IDLE->BUSY on acceptance of 1001-1100 and load an iteration counter with n.
REQ-026 SHALL, in BUSY, perform one shift-add step (MUL/MULHU) or one restoring-division step (DIVU/REMU) per cycle, decrementing the counter.
REQ-027 SHALL move BUSY->DONE when the counter reaches 0, giving out_valid n+1 cycles after acceptance.
REQ-028 SHALL hold alu_out and zero stable in DONE until out_ready = 1, then move DONE->IDLE on that edge.
REQ-029 SHALL ignore in_valid while in BUSY or DONE, with no capture and no side effect.
REQ-030 SHALL, on divide by zero, still take n+1 cycles and give DIVU = all-ones and REMU = inp1.
REQ-031 SHALL compute zero from the value written into alu_out in the same edge.

Reset
REQ-032 SHALL, while rst_n = 0, force state IDLE, counter 0, alu_out 0, zero 0 and out_valid 0; in_ready = 1 after release.
REQ-033 SHALL, on reset asserted mid-BUSY or mid-DONE, discard the operation; no result is ever presented for it.
REQ-034 SHALL accept a new operation on the first rising edge after rst_n deasserts, if in_valid = 1.

Verification
REQ-035 SHALL cover (n=32) ADD 5+7 with out_ready=1 -> alu_out=12, zero=0, out_valid 1 cycle after accept; SUB 7-7 -> 0, zero=1.
REQ-036 SHALL cover SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SLL 1 by 33 -> 2.
REQ-037 SHALL cover MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE and MULHU same -> 1, each with out_valid exactly 33 cycles after accept and in_ready=0 meanwhile.
REQ-038 SHALL cover DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-039 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> alu_out held; in_valid pulses with new operands are ignored; first op's result is returned once.
REQ-040 SHALL cover reset asserted at counter=16 during DIVU -> outputs zero immediately, in_ready=1 after release, next ADD completes correctly.
